ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the press counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port fifo_data  input  8  scan-code byte at the head of the upstream PS/2 receiver FIFO.
REQ-005 SHALL have port fifo_ready  input  1  upstream FIFO non-empty; fifo_data valid.
REQ-006 SHALL have port fifo_overflow  input  1  upstream FIFO overflow flag.
REQ-007 SHALL have port nextdata_n  output  1  active-low pop strobe to the upstream FIFO.
REQ-008 SHALL have port key_code  output  8  scan code of the currently held key; 8'h00 when none is held.
REQ-009 SHALL have port key_ext  output  1  held key carried the E0 prefix.
REQ-010 SHALL have port key_down  output  1  a tracked key is held.
REQ-011 SHALL have port press_pulse  output  1  one-cycle strobe on a new press.
REQ-012 SHALL have port release_pulse  output  1  one-cycle strobe on release of the tracked key.
REQ-013 SHALL have port press_count  output  CNT_W  number of new presses since reset.
REQ-014 SHALL have port err  output  1  sticky error flag.

Function
REQ-015 Acceptance: a byte SHALL be accepted at an edge where fifo_ready=1 and nextdata_n=1. At that edge the byte is decoded, outputs are updated, and nextdata_n is driven 0.
REQ-016 nextdata_n SHALL be low for exactly one cycle per accepted byte. It SHALL then return to 1, giving a maximum throughput of one byte per 2 cycles.
REQ-017 The prefix FSM SHALL have states NONE, EXT, BRK and EXT_BRK.
REQ-018 FSM transitions:
- NONE: E0 -> EXT; F0 -> BRK; any other code -> make (ext=0).
- EXT: F0 -> EXT_BRK; E0 -> stay in EXT; any other code -> make (ext=1), then NONE.
REQ-019 Make of code c, ext e:
- If key_down=1, key_code=c and key_ext=e: typematic repeat; no pulse, no count change.
- Otherwise: key_code<=c, key_ext<=e, key_down<=1, press_pulse=1, press_count+1.
REQ-020 Break (BRK or EXT_BRK) of code c:
- If c and ext match the held key: key_down<=0, key_code<=00, key_ext<=0, release_pulse=1.
- Otherwise: ignored.
- In both cases the FSM returns to NONE.
REQ-021 Only the most recent press SHALL be tracked (rollover); a new make of a different key replaces the held key without a release_pulse.
REQ-022 press_count SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-023 Error conditions:
- Byte 00 or FF in any state: err<=1, FSM to NONE, no other output change.
- E0 or F0 received in BRK or EXT_BRK: err<=1, FSM to NONE.
REQ-024 fifo_overflow=1 on any cycle SHALL set err; err SHALL clear only on rst.
REQ-025 press_pulse and release_pulse SHALL be registered and SHALL be 0 in every cycle without an accepted qualifying byte.

Reset
REQ-026 While rst=1, at the clock edge:
- nextdata_n=1; key_code=00; key_ext=0; key_down=0.
- press_pulse=0; release_pulse=0; press_count=0; err=0; FSM in NONE.
REQ-027 rst SHALL take priority over acceptance. A byte whose pop was already issued is discarded, not re-fetched.
REQ-028 No byte SHALL be accepted at an edge where rst=1.

Structure
REQ-029 Package ps2_pkg SHALL hold:
- constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_ERR_LO=8'h00, PS2_ERR_HI=8'hFF;
- the prefix-state enum.
REQ-030 The design SHALL be a single module with no sub-module. The FSM, tracking registers and counter are inline; the downstream seven-segment and ASCII stages consume key_code and press_count.

Verification
REQ-031 rst, then bytes 1C -> exactly one press_pulse; key_code=1C, key_down=1, press_count=1; nextdata_n low for exactly 1 cycle.
REQ-032 1C,1C,1C,F0,1C -> press_count=1 and one release_pulse; final key_code=00, key_down=0.
REQ-033 E0,75,E0,F0,75 -> key_ext=1 and key_code=75 with press_count=1, then one release_pulse; final key_down=0, key_ext=0.
REQ-034 1C,32,F0,1C -> key_code=32, press_count=2, no release_pulse. Then F0,32 -> release_pulse, key_down=0.
REQ-035 256 alternating makes 1C/32 with fifo_ready held high -> press_count=00; one byte accepted every 2 cycles.
REQ-036 Error and reset sequence:
- Byte FF -> err=1, no pulses.
- rst -> err=0.
- F0,E0 -> err=1.
- One-cycle fifo_overflow -> err stays 1 until rst.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and prefix-state type for the PS/2 scan-code decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_ERR_LO = 8'h00;
  localparam logic [7:0] PS2_ERR_HI = 8'hFF;

  typedef enum logic [1:0] {
    StNone,
    StExt,
    StBrk,
    StExtBrk
  } ps2_pfx_e;

  function automatic logic ps2_is_err_byte(input logic [7:0] b);
    return (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
  endfunction

endpackage

// File: rtl/ps2_key_decoder.sv
// Decodes PS/2 set-2 scan codes popped from a receiver FIFO into held-key
// state, press/release strobes, a press counter and a sticky error flag.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_ready,
  input  logic             fifo_overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic [CNT_W-1:0] press_count,
  output logic             err
);

  ps2_pfx_e         r_state;
  logic             r_nextdata_n;
  logic [7:0]       r_key_code;
  logic             r_key_ext;
  logic             r_key_down;
  logic             r_press_pulse;
  logic             r_release_pulse;
  logic [CNT_W-1:0] r_press_count;
  logic             r_err;

  ps2_pfx_e         w_state_d;
  logic             w_nextdata_n_d;
  logic [7:0]       w_key_code_d;
  logic             w_key_ext_d;
  logic             w_key_down_d;
  logic             w_press_pulse_d;
  logic             w_release_pulse_d;
  logic [CNT_W-1:0] w_press_count_d;
  logic             w_err_d;

  logic             w_accept;
  logic             w_pfx_ext;
  logic             w_in_brk;
  logic             w_match;

  // nextdata_n doubles as the "not popping" flag, so a byte is never taken
  // while its pop is still in flight.
  assign w_accept  = fifo_ready & r_nextdata_n;
  assign w_pfx_ext = (r_state == StExt) || (r_state == StExtBrk);
  assign w_in_brk  = (r_state == StBrk) || (r_state == StExtBrk);
  assign w_match   = r_key_down && (r_key_code == fifo_data) && (r_key_ext == w_pfx_ext);

  always_comb begin
    w_state_d         = r_state;
    w_nextdata_n_d    = 1'b1;
    w_key_code_d      = r_key_code;
    w_key_ext_d       = r_key_ext;
    w_key_down_d      = r_key_down;
    w_press_pulse_d   = 1'b0;
    w_release_pulse_d = 1'b0;
    w_press_count_d   = r_press_count;
    w_err_d           = r_err | fifo_overflow;

    if (w_accept) begin
      w_nextdata_n_d = 1'b0;
      if (ps2_is_err_byte(fifo_data)) begin
        w_err_d   = 1'b1;
        w_state_d = StNone;
      end else if ((fifo_data == PS2_EXT) || (fifo_data == PS2_BRK)) begin
        if (w_in_brk) begin
          w_err_d   = 1'b1;
          w_state_d = StNone;
        end else if (fifo_data == PS2_BRK) begin
          w_state_d = w_pfx_ext ? StExtBrk : StBrk;
        end else begin
          w_state_d = StExt;
        end
      end else if (w_in_brk) begin
        // Breaks of anything but the tracked key are dropped silently.
        if (w_match) begin
          w_key_code_d      = 8'h00;
          w_key_ext_d       = 1'b0;
          w_key_down_d      = 1'b0;
          w_release_pulse_d = 1'b1;
        end
        w_state_d = StNone;
      end else begin
        // A matching make is typematic repeat and changes nothing.
        if (!w_match) begin
          w_key_code_d    = fifo_data;
          w_key_ext_d     = w_pfx_ext;
          w_key_down_d    = 1'b1;
          w_press_pulse_d = 1'b1;
          w_press_count_d = r_press_count + CNT_W'(1);
        end
        w_state_d = StNone;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= StNone;
      r_nextdata_n    <= 1'b1;
      r_key_code      <= 8'h00;
      r_key_ext       <= 1'b0;
      r_key_down      <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_press_count   <= '0;
      r_err           <= 1'b0;
    end else begin
      r_state         <= w_state_d;
      r_nextdata_n    <= w_nextdata_n_d;
      r_key_code      <= w_key_code_d;
      r_key_ext       <= w_key_ext_d;
      r_key_down      <= w_key_down_d;
      r_press_pulse   <= w_press_pulse_d;
      r_release_pulse <= w_release_pulse_d;
      r_press_count   <= w_press_count_d;
      r_err           <= w_err_d;
    end
  end

  assign nextdata_n    = r_nextdata_n;
  assign key_code      = r_key_code;
  assign key_ext       = r_key_ext;
  assign key_down      = r_key_down;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign press_count   = r_press_count;
  assign err           = r_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized and directed bench for ps2_key_decoder against a behavioural
// key-tracking model fed from a queue standing in for the upstream FIFO.
module tb_ps2_key_decoder;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    fifo_data = 8'h00;
  logic          fifo_ready = 1'b0;
  logic          fifo_overflow = 1'b0;
  logic          nextdata_n;
  logic [7:0]    key_code;
  logic          key_ext;
  logic          key_down;
  logic          press_pulse;
  logic          release_pulse;
  logic [CW-1:0] press_count;
  logic          err;

  ps2_key_decoder #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_data    (fifo_data),
    .fifo_ready   (fifo_ready),
    .fifo_overflow(fifo_overflow),
    .nextdata_n   (nextdata_n),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_down     (key_down),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_count  (press_count),
    .err          (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] q[$];
  bit stall = 1'b0;

  // Model: held key, pending prefixes as two flags, counters as integers.
  bit         m_valid = 1'b0;
  bit         m_nd = 1'b1;
  logic [7:0] m_code = 8'h00;
  bit         m_ext, m_down, m_pp, m_rp, m_err, p_ext, p_brk;
  int         m_cnt = 0;
  int         seen_pp, seen_rp, seen_ndlow;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic decode(input logic [7:0] b);
    bit held_same;
    held_same = m_down && (m_code == b) && (m_ext == p_ext);
    if (b == 8'h00 || b == 8'hFF) begin
      m_err = 1; p_ext = 0; p_brk = 0;
    end else if (b == 8'hE0 || b == 8'hF0) begin
      if (p_brk) begin
        m_err = 1; p_ext = 0; p_brk = 0;
      end else if (b == 8'hF0) p_brk = 1;
      else p_ext = 1;
    end else begin
      if (p_brk) begin
        if (held_same) begin
          m_down = 0; m_code = 8'h00; m_ext = 0; m_rp = 1;
        end
      end else if (!held_same) begin
        m_code = b; m_ext = p_ext; m_down = 1; m_pp = 1;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
      p_ext = 0; p_brk = 0;
    end
  endtask

  task automatic model_edge();
    bit pop;
    pop = !m_nd;
    if (rst) begin
      m_valid = 1; m_nd = 1; m_code = 8'h00; m_ext = 0; m_down = 0;
      m_pp = 0; m_rp = 0; m_cnt = 0; m_err = 0; p_ext = 0; p_brk = 0;
    end else begin
      m_pp = 0; m_rp = 0;
      if (fifo_overflow) m_err = 1;
      if (fifo_ready && m_nd) begin
        m_nd = 0;
        decode(fifo_data);
      end else begin
        m_nd = 1;
      end
    end
    // The FIFO pops on any edge where the strobe was low, reset or not.
    if (pop && q.size() > 0) void'(q.pop_front());
  endtask

  task automatic compare();
    if (!m_valid) return;
    chk("nextdata_n", 32'(nextdata_n), 32'(m_nd));
    chk("key_code", 32'(key_code), 32'(m_code));
    chk("key_ext", 32'(key_ext), 32'(m_ext));
    chk("key_down", 32'(key_down), 32'(m_down));
    chk("press_pulse", 32'(press_pulse), 32'(m_pp));
    chk("release_pulse", 32'(release_pulse), 32'(m_rp));
    chk("press_count", 32'(press_count), 32'(m_cnt));
    chk("err", 32'(err), 32'(m_err));
    if (press_pulse === 1'b1) seen_pp++;
    if (release_pulse === 1'b1) seen_rp++;
    if (nextdata_n === 1'b0) seen_ndlow++;
  endtask

  task automatic drive();
    fifo_ready = (q.size() > 0) && !stall;
    fifo_data  = (q.size() > 0) ? q[0] : 8'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    compare();
    drive();
  endtask

  task automatic clear_seen();
    seen_pp = 0; seen_rp = 0; seen_ndlow = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive();
    clear_seen();
  endtask

  task automatic drain(input int max, output int n);
    n = 0;
    drive();
    while (!(q.size() == 0 && m_nd)) begin
      if (n >= max) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout cyc=%0d got=%0d cycles exp<=%0d", cyc, n, max);
        q.delete();
        m_nd = 1;
        break;
      end
      step();
      n++;
    end
  endtask

  function automatic logic [7:0] pick();
    int r;
    r = $urandom_range(0, 39);
    if (r < 10) return 8'h1C;
    if (r < 16) return 8'h32;
    if (r < 20) return 8'h75;
    if (r < 26) return 8'hE0;
    if (r < 33) return 8'hF0;
    if (r == 33) return ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
    return 8'($urandom);
  endfunction

  int n;

  initial begin
    clear_seen();
    @(negedge clk);
    do_reset();
    chk("rst_code", 32'(key_code), 32'h00);
    chk("rst_down", 32'(key_down), 32'h0);
    chk("rst_count", 32'(press_count), 32'h0);
    chk("rst_nd", 32'(nextdata_n), 32'h1);

    // Single press
    q.push_back(8'h1C);
    drain(20, n);
    chk("p1_code", 32'(key_code), 32'h1C);
    chk("p1_down", 32'(key_down), 32'h1);
    chk("p1_count", 32'(press_count), 32'h1);
    chk("p1_pulses", 32'(seen_pp), 32'd1);
    chk("p1_ndlow", 32'(seen_ndlow), 32'd1);

    // Typematic repeat then release
    do_reset();
    foreach (q[i]) q.delete(i);
    q = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    drain(40, n);
    chk("rep_count", 32'(press_count), 32'h1);
    chk("rep_pp", 32'(seen_pp), 32'd1);
    chk("rep_rp", 32'(seen_rp), 32'd1);
    chk("rep_code", 32'(key_code), 32'h00);
    chk("rep_down", 32'(key_down), 32'h0);

    // Extended key
    do_reset();
    q = '{8'hE0, 8'h75};
    drain(20, n);
    chk("ext_ext", 32'(key_ext), 32'h1);
    chk("ext_code", 32'(key_code), 32'h75);
    chk("ext_count", 32'(press_count), 32'h1);
    q = '{8'hE0, 8'hF0, 8'h75};
    drain(20, n);
    chk("ext_rp", 32'(seen_rp), 32'd1);
    chk("ext_down", 32'(key_down), 32'h0);
    chk("ext_ext0", 32'(key_ext), 32'h0);

    // Rollover: stale break ignored
    do_reset();
    q = '{8'h1C, 8'h32, 8'hF0, 8'h1C};
    drain(30, n);
    chk("roll_code", 32'(key_code), 32'h32);
    chk("roll_count", 32'(press_count), 32'h2);
    chk("roll_rp", 32'(seen_rp), 32'd0);
    q = '{8'hF0, 8'h32};
    drain(20, n);
    chk("roll_rp2", 32'(seen_rp), 32'd1);
    chk("roll_down", 32'(key_down), 32'h0);

    // Counter wrap and throughput
    do_reset();
    for (int i = 0; i < 256; i++) q.push_back((i % 2 == 0) ? 8'h1C : 8'h32);
    drain(600, n);
    chk("wrap_count", 32'(press_count), 32'h0);
    chk("wrap_cycles", 32'(n), 32'd512);
    chk("wrap_ndlow", 32'(seen_ndlow), 32'd256);
    chk("wrap_pp", 32'(seen_pp), 32'd256);

    // Errors
    do_reset();
    q = '{8'hFF};
    drain(20, n);
    chk("ff_err", 32'(err), 32'h1);
    chk("ff_pulses", 32'(seen_pp + seen_rp), 32'd0);
    do_reset();
    chk("rst_err", 32'(err), 32'h0);
    q = '{8'hF0, 8'hE0};
    drain(20, n);
    chk("fe_err", 32'(err), 32'h1);
    do_reset();
    fifo_overflow = 1'b1;
    step();
    fifo_overflow = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("ovf_err", 32'(err), 32'h1);
    do_reset();
    chk("ovf_clr", 32'(err), 32'h0);

    // Random traffic with stalls, overflow and reset
    for (int i = 0; i < 3000; i++) begin
      if (q.size() < 4 && $urandom_range(0, 2) != 0) q.push_back(pick());
      stall = ($urandom_range(0, 3) == 0);
      fifo_overflow = ($urandom_range(0, 299) == 0);
      rst = ($urandom_range(0, 149) == 0);
      drive();
      step();
    end
    rst = 1'b0;
    fifo_overflow = 1'b0;
    stall = 1'b0;
    drain(100, n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
